// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: circular {pc, instruction} FIFO between fetch and decode.
// Holds fetched instructions while decode stalls; flush empties it on a redirect.
// in_ready and out_valid are decoded from the count register only, so neither
// has a combinational path from deq_stall or flush.
module inst_fetch_queue #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [ADDR_WIDTH-1:0]      in_pc,
  input  logic [DATA_WIDTH-1:0]      in_data,
  output logic                       in_ready,
  input  logic                       flush,
  input  logic                       deq_stall,
  output logic                       out_valid,
  output logic [ADDR_WIDTH-1:0]      out_pc,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Entry storage; never cleared, because out_valid gates everything it shows.
  logic [ADDR_WIDTH-1:0] r_pc_mem   [DEPTH];
  logic [DATA_WIDTH-1:0] r_data_mem [DEPTH];

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;
  logic w_clear;

  assign in_ready  = (r_count != FULL_CNT);
  assign out_valid = (r_count != '0);
  assign occupancy = r_count;

  // A full queue refuses pushes; an empty queue ignores deq_stall entirely.
  assign w_push  = in_valid && in_ready;
  assign w_pop   = out_valid && !deq_stall;
  assign w_clear = rst || flush;

  // Head entry is shown only when valid; otherwise the outputs are forced to zero.
  always_comb begin
    out_pc   = '0;
    out_data = '0;
    if (out_valid) begin
      out_pc   = r_pc_mem[r_head];
      out_data = r_data_mem[r_head];
    end
  end

  // Capture the fetched pair at the tail; a push in a flush/reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (w_push && !w_clear) begin
      r_pc_mem[r_tail]   <= in_pc;
      r_data_mem[r_tail] <= in_data;
    end
  end

  // Pointer and count update; reset and flush both empty the queue and rewind to 0.
  // DEPTH is a power of two, so pointer overflow is exactly the wrap DEPTH-1 -> 0.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed scenarios plus random traffic, checked against a
// queue-based reference model of the instruction FIFO.
module tb_inst_fetch_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [AW-1:0] in_pc;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          flush;
  logic          deq_stall;
  logic          out_valid;
  logic [AW-1:0] out_pc;
  logic [DW-1:0] out_data;
  logic [2:0]    occupancy;

  int total = 0;
  int bad   = 0;

  // Reference model: oldest entry at index 0, each entry is {pc, data}.
  logic [AW+DW-1:0] model_q[$];

  inst_fetch_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_pc(in_pc), .in_data(in_data), .in_ready(in_ready),
    .flush(flush), .deq_stall(deq_stall),
    .out_valid(out_valid), .out_pc(out_pc), .out_data(out_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] pc);
    return {pc[15:0], ~pc[15:0]} ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output against what the model's current contents imply.
  task automatic check_model(input string tag);
    logic [AW-1:0] e_pc;
    logic [DW-1:0] e_data;
    e_pc   = '0;
    e_data = '0;
    if (model_q.size() != 0) begin
      e_pc   = model_q[0][AW+DW-1:DW];
      e_data = model_q[0][DW-1:0];
    end
    chk({tag, ".valid"}, 64'(out_valid), 64'(model_q.size() != 0));
    chk({tag, ".pc"},    64'(out_pc),    64'(e_pc));
    chk({tag, ".data"},  64'(out_data),  64'(e_data));
    chk({tag, ".ready"}, 64'(in_ready),  64'(model_q.size() < DEPTH));
    chk({tag, ".occ"},   64'(occupancy), 64'(model_q.size()));
  endtask

  // One clock cycle: apply inputs, check registered state (no bypass allowed),
  // then advance the model by the FIFO rules at the edge.
  task automatic cycle(input string tag, input logic v, input logic [AW-1:0] pc,
                       input logic [DW-1:0] d, input logic st, input logic fl,
                       input logic r);
    bit do_push, do_pop;
    in_valid  = v;
    in_pc     = pc;
    in_data   = d;
    deq_stall = st;
    flush     = fl;
    rst       = r;
    #1;
    check_model(tag);
    do_push = v && (model_q.size() < DEPTH);
    do_pop  = (model_q.size() != 0) && !st;
    @(posedge clk);
    if (r || fl) begin
      model_q.delete();
    end else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back({pc, d});
    end
    #1;
    $display("cycle %-8s v=%0b pc=%h st=%0b fl=%0b rst=%0b -> occ=%0d out_valid=%0b out_pc=%h",
             tag, v, pc, st, fl, r, occupancy, out_valid, out_pc);
  endtask

  task automatic idle(input string tag, input logic st);
    cycle(tag, 1'b0, '0, '0, st, 1'b0, 1'b0);
  endtask

  task automatic push(input string tag, input logic [AW-1:0] pc, input logic st);
    cycle(tag, 1'b1, pc, word_of(pc), st, 1'b0, 1'b0);
  endtask

  initial begin
    in_valid = 0; in_pc = '0; in_data = '0; deq_stall = 0; flush = 0; rst = 1;
    @(posedge clk);
    #1;
    cycle("reset", 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    chk("rst.valid", 64'(out_valid), 64'd0);
    chk("rst.ready", 64'(in_ready), 64'd1);
    chk("rst.occ",   64'(occupancy), 64'd0);

    // Fill while decode is stalled; the fifth push must be refused.
    for (int i = 0; i < 4; i++) push("fill", 32'h100 + 32'(4 * i), 1'b1);
    chk("full.occ",   64'(occupancy), 64'd4);
    chk("full.ready", 64'(in_ready),  64'd0);
    push("fill5", 32'h110, 1'b1);
    chk("full5.occ", 64'(occupancy), 64'd4);
    chk("full5.pc",  64'(out_pc),    64'h100);

    // Drain: one entry per cycle, in_ready back after the first pop.
    idle("drain", 1'b0);
    chk("drain.ready", 64'(in_ready), 64'd1);
    chk("drain.pc1",   64'(out_pc),   64'h104);
    for (int i = 0; i < 3; i++) idle("drain", 1'b0);
    chk("drained.valid", 64'(out_valid), 64'd0);
    chk("drained.pc",    64'(out_pc),    64'd0);

    // Streaming: push and pop every cycle, occupancy pinned at 1 after the first.
    for (int i = 0; i < 12; i++) begin
      push("stream", 32'(4 * i), 1'b0);
      chk("stream.occ", 64'(occupancy), 64'd1);
      chk("stream.pc",  64'(out_pc),    64'(4 * i));
    end
    idle("stream_end", 1'b0);

    // Flush with 3 entries queued and a push of 0x200 in the flush cycle.
    for (int i = 0; i < 3; i++) push("preflush", 32'h180 + 32'(4 * i), 1'b1);
    cycle("flush", 1'b1, 32'h200, word_of(32'h200), 1'b1, 1'b1, 1'b0);
    chk("flush.occ",   64'(occupancy), 64'd0);
    chk("flush.valid", 64'(out_valid), 64'd0);
    push("postflush", 32'h300, 1'b1);
    chk("postflush.pc", 64'(out_pc), 64'h300);
    idle("postflush", 1'b0);
    chk("postflush.empty", 64'(out_valid), 64'd0);

    // Reset mid-operation with 2 entries queued.
    push("prerst", 32'h500, 1'b1);
    push("prerst", 32'h504, 1'b1);
    cycle("midrst", 1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    chk("midrst.occ", 64'(occupancy), 64'd0);
    push("postrst", 32'h600, 1'b1);
    chk("postrst.pc", 64'(out_pc), 64'h600);
    idle("postrst", 1'b0);

    // Empty queue ignores deq_stall; a later push shows up one cycle later.
    for (int i = 0; i < 4; i++) idle("emptypop", 1'(i));
    chk("emptypop.occ", 64'(occupancy), 64'd0);
    push("push400", 32'h400, 1'b1);
    chk("push400.pc", 64'(out_pc), 64'h400);
    idle("drain400", 1'b0);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      logic [AW-1:0] rpc;
      rpc = $urandom & 32'hFFFF_FFFC;
      cycle("rand", 1'($urandom_range(0, 3) != 0), rpc, $urandom,
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 19) == 0),
            1'($urandom_range(0, 49) == 0));
    end
    idle("final", 1'b0);
    check_model("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
